// File: rtl/btn_press_classifier_pkg.sv
// Shared types and helpers for the button press classifier.
package btn_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG_HOLD,
        WAIT_GAP,
        PRESS2
    } btn_state_t;

    // 64-bit math: CLOCK_FREQ * ms overflows 32 bits at realistic clock rates.
    function automatic longint unsigned ms_to_cycles(input longint unsigned freq_hz,
                                                     input longint unsigned ms);
        return freq_hz * ms / 64'd1000;
    endfunction

endpackage

// File: rtl/btn_press_classifier_if.sv
// Debounced level in, classified press events out.
interface btn_press_classifier_if;
    logic debounced_i;
    logic short_press_o;
    logic long_press_o;
    logic double_press_o;
    logic held_o;

    modport master (output debounced_i,
                    input  short_press_o, long_press_o, double_press_o, held_o);
    modport slave  (input  debounced_i,
                    output short_press_o, long_press_o, double_press_o, held_o);
endinterface

// File: rtl/btn_press_classifier_edge_det.sv
// Rising-edge detector; the history register resets high so a button
// held through reset must be released before it can register a press.
module btn_edge_det (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic level_i,
    output logic rise_o
);
    logic d_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) d_q <= 1'b1;
        else           d_q <= level_i;
    end

    assign rise_o = level_i & ~d_q;
endmodule

// File: rtl/btn_press_classifier.sv
// Classifies debounced button presses into short / long / double events
// with one-cycle registered pulses and a held level.
module btn_press_classifier
    import btn_evt_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ    = 10_000_000,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned DOUBLE_GAP_MS = 300,
    parameter int unsigned WIDTH_COUNTER = 24
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    btn_press_classifier_if.slave  btn
);
    localparam longint unsigned LONG_CYCLES = ms_to_cycles(CLOCK_FREQ, LONG_PRESS_MS);
    localparam longint unsigned GAP_CYCLES  = ms_to_cycles(CLOCK_FREQ, DOUBLE_GAP_MS);
    localparam longint unsigned CNT_LIMIT   = longint'(1) << WIDTH_COUNTER;
    localparam logic [WIDTH_COUNTER-1:0] LONG_LAST = WIDTH_COUNTER'(LONG_CYCLES - 1);
    localparam logic [WIDTH_COUNTER-1:0] GAP_LAST  = WIDTH_COUNTER'(GAP_CYCLES - 1);

    if (LONG_CYCLES < 2 || GAP_CYCLES < 1) begin : g_bad_cycles
        $error("btn_press_classifier: need LONG_CYCLES >= 2 and GAP_CYCLES >= 1");
    end
    if (LONG_CYCLES >= CNT_LIMIT || GAP_CYCLES >= CNT_LIMIT) begin : g_bad_width
        $error("btn_press_classifier: WIDTH_COUNTER too small for the cycle counts");
    end

    btn_state_t               state_q;
    logic [WIDTH_COUNTER-1:0] cnt_q;
    logic                     short_q, long_q, double_q, held_q;
    logic                     rise;

    btn_edge_det u_edge (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .level_i  (btn.debounced_i),
        .rise_o   (rise)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            case (state_q)
                IDLE: if (rise) begin
                    state_q <= PRESS1;
                    cnt_q   <= '0;
                    held_q  <= 1'b1;
                end
                PRESS1: begin
                    if (!btn.debounced_i) begin
                        state_q <= WAIT_GAP;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q <= LONG_HOLD;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LONG_HOLD: if (!btn.debounced_i) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
                // A second rise beats gap expiry on the same edge.
                WAIT_GAP: begin
                    if (rise) begin
                        state_q  <= PRESS2;
                        cnt_q    <= '0;
                        double_q <= 1'b1;
                        held_q   <= 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        short_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESS2: if (!btn.debounced_i) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign btn.short_press_o  = short_q;
    assign btn.long_press_o   = long_q;
    assign btn.double_press_o = double_q;
    assign btn.held_o         = held_q;
endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed and random press sequences checked against a run-length model.
module tb_btn_press_classifier;
    localparam int L    = 10;
    localparam int G    = 4;
    localparam int MAXN = 256;

    logic clk = 1'b0;
    logic reset_ni;
    always #5 clk = ~clk;

    btn_press_classifier_if bus ();

    btn_press_classifier #(
        .CLOCK_FREQ    (1000),
        .LONG_PRESS_MS (10),
        .DOUBLE_GAP_MS (4),
        .WIDTH_COUNTER (24)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .btn      (bus)
    );

    bit         stim  [MAXN];
    logic [3:0] exp_o [MAXN];   // {short, long, double, held} after edge n
    int         nstim;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b (short,long,double,held)", tag, got, want);
        end
    endtask

    task automatic add_seg(input bit lvl, input int len);
        for (int i = 0; i < len; i++) begin
            stim[nstim] = lvl;
            nstim++;
        end
    endtask

    function automatic int run_end(input int i, input bit lvl, input int hi);
        int j = i;
        while (j < hi && stim[j] == lvl) j++;
        return j;
    endfunction

    // Expected outputs for samples lo..hi-1, with reset (level history = 1) just before lo.
    task automatic model(input int lo, input int hi);
        int p, r, e, ge, e2;
        for (int i = lo; i < hi; i++) exp_o[i] = 4'b0000;
        p = lo;
        while (p < hi) begin
            r = -1;
            for (int i = p; i < hi && r < 0; i++)
                if (stim[i] && i > lo && !stim[i-1]) r = i;
            if (r < 0) break;
            e = run_end(r, 1'b1, hi);
            for (int i = r; i < e; i++) exp_o[i][0] = 1'b1;
            if (e - r >= L + 1) begin
                exp_o[r+L][2] = 1'b1;
                p = e + 1;
                continue;
            end
            if (e >= hi) break;
            ge = run_end(e, 1'b0, hi);
            if (ge < hi && ge - e <= G) begin
                exp_o[ge][1] = 1'b1;
                e2 = run_end(ge, 1'b1, hi);
                for (int i = ge; i < e2; i++) exp_o[i][0] = 1'b1;
                p = e2 + 1;
            end else if (e + G < hi) begin
                exp_o[e+G][3] = 1'b1;
                p = e + G + 1;
            end else begin
                break;
            end
        end
    endtask

    task automatic run(input string name, input bit init_lvl, input int rst_at);
        logic [3:0] got;
        @(negedge clk);
        reset_ni        = 1'b0;
        bus.debounced_i = init_lvl;
        repeat (2) @(posedge clk);
        #1;
        got = {bus.short_press_o, bus.long_press_o, bus.double_press_o, bus.held_o};
        chk($sformatf("%s/reset", name), got, 4'b0000);
        if (rst_at < 0) begin
            model(0, nstim);
        end else begin
            model(0, rst_at);
            exp_o[rst_at] = 4'b0000;
            model(rst_at + 1, nstim);
        end
        for (int n = 0; n < nstim; n++) begin
            @(negedge clk);
            reset_ni        = (n == rst_at) ? 1'b0 : 1'b1;
            bus.debounced_i = stim[n];
            @(posedge clk);
            #1;
            got = {bus.short_press_o, bus.long_press_o, bus.double_press_o, bus.held_o};
            chk($sformatf("%s/n%0d", name, n), got, exp_o[n]);
        end
    endtask

    initial begin
        reset_ni        = 1'b0;
        bus.debounced_i = 1'b0;

        nstim = 0; add_seg(0, 2); add_seg(1, 3); add_seg(0, 10);
        run("short", 1'b0, -1);

        nstim = 0; add_seg(0, 2); add_seg(1, 20); add_seg(0, 10);
        run("long", 1'b0, -1);

        nstim = 0; add_seg(0, 2); add_seg(1, 3); add_seg(0, 2); add_seg(1, 3); add_seg(0, 10);
        run("double", 1'b0, -1);

        nstim = 0; add_seg(0, 2); add_seg(1, 3); add_seg(0, G); add_seg(1, 3); add_seg(0, 10);
        run("gap_edge_dbl", 1'b0, -1);

        nstim = 0; add_seg(0, 2); add_seg(1, 3); add_seg(0, G + 1); add_seg(1, 3); add_seg(0, 10);
        run("gap_edge_short", 1'b0, -1);

        nstim = 0; add_seg(1, 30); add_seg(0, 3); add_seg(1, 3); add_seg(0, 10);
        run("held_thru_reset", 1'b1, -1);

        nstim = 0; add_seg(0, 2); add_seg(1, 12); add_seg(0, 10);
        run("mid_reset", 1'b0, 7);

        for (int k = 0; k < 8; k++) begin
            int rst_at;
            nstim = 0;
            add_seg(0, 2);
            while (nstim < 150) begin
                add_seg(1, int'($urandom_range(1, 14)));
                add_seg(0, int'($urandom_range(1, 7)));
            end
            add_seg(0, 10);
            rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, nstim - 5)) : -1;
            run($sformatf("rand%0d", k), 1'(($urandom_range(0, 1))), rst_at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
